// File: rtl/fpu_dispatch_if.sv
// Producer-to-queue and queue-to-fpu handshake bundle for fpu_dispatch.
// master drives requests and fpu accepts; slave is the dispatch queue itself.
interface fpu_dispatch_if #(
   parameter int bitness = 32
);
   logic               req_rdy;
   logic               req_ack;
   logic [bitness-1:0] req_a;
   logic [bitness-1:0] req_b;
   logic [3:0]         req_command;
   logic               fpu_input_rdy;
   logic               fpu_input_ack;
   logic [bitness-1:0] fpu_data_a;
   logic [bitness-1:0] fpu_data_b;
   logic [3:0]         fpu_command;

   modport master (
      output req_rdy, req_a, req_b, req_command, fpu_input_ack,
      input  req_ack, fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_command
   );

   modport slave (
      input  req_rdy, req_a, req_b, req_command, fpu_input_ack,
      output req_ack, fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_command
   );
endinterface

// File: rtl/fpu_dispatch.sv
// Operation queue in front of an fpu: 1-cycle push-to-head latency, strict FIFO order.
// req_ack drops while full; invalid opcodes are accepted, dropped and flagged in sticky cmd_err.
module fpu_dispatch #(
   parameter int bitness = 32,
   parameter int depth   = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   fpu_dispatch_if.slave          bus,
   output logic [$clog2(depth):0] count,
   output logic                   cmd_err,
   input  logic                   err_clear
);
   localparam int ptr_w = $clog2(depth);
   localparam logic [ptr_w:0] full_count = (ptr_w + 1)'(depth);

   typedef struct packed {
      logic [3:0]         command;
      logic [bitness-1:0] b;
      logic [bitness-1:0] a;
   } entry_t;

   entry_t           mem [depth];
   entry_t           head;
   logic [ptr_w-1:0] wr_ptr;
   logic [ptr_w-1:0] rd_ptr;
   logic             op_valid;
   logic             push;
   logic             store;
   logic             pop;

   // add/sub/mul/div occupy opcodes 0..3, so the upper two bits must be clear
   assign op_valid = (bus.req_command[3:2] == 2'b00);
   assign push     = bus.req_rdy & bus.req_ack;
   assign store    = push & op_valid;
   assign pop      = bus.fpu_input_rdy & bus.fpu_input_ack;

   assign bus.req_ack       = reset & (count < full_count);
   assign bus.fpu_input_rdy = (count != '0);

   // Empty queue shows zeros so stale entries never leak after reset or drain
   assign head           = bus.fpu_input_rdy ? mem[rd_ptr] : '0;
   assign bus.fpu_data_a = head.a;
   assign bus.fpu_data_b = head.b;
   assign bus.fpu_command = head.command;

   always_ff @(posedge clock) begin
      if (store) begin
         mem[wr_ptr] <= '{command: bus.req_command, b: bus.req_b, a: bus.req_a};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         cmd_err <= 1'b0;
      end else begin
         if (store) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({store, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !op_valid) begin
            cmd_err <= 1'b1;
         end else if (err_clear) begin
            cmd_err <= 1'b0;
         end
      end
   end
endmodule
